// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - FIFO link between ps2_keyboard (master) and ps2_key_decoder (slave)
interface ps2_fifo_if;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;

    modport master (output data, output ready, output overflow, input nextdata_n);
    modport slave  (input data, input ready, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - set-2 scan code to key event decoder with prefix, held-key and ASCII tracking
module ps2_key_decoder #(
    parameter bit ASCII_EN = 1'b1
) (
    input  logic           clk,
    input  logic           clrn,
    ps2_fifo_if.slave      fifo,
    output logic           key_valid,
    output logic [7:0]     key_code,
    output logic           key_ext,
    output logic           key_break,
    output logic           key_repeat,
    output logic [7:0]     key_ascii,
    output logic           held,
    output logic [7:0]     press_count,
    output logic           sync_err
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t     state_q;
    logic       nextdata_n_q;
    logic       key_valid_q, key_ext_q, key_break_q, key_repeat_q;
    logic [7:0] key_code_q, key_ascii_q, press_count_q;
    logic       held_q, sync_err_q;
    logic       pe_q, pb_q;
    logic [7:0] hcode_q;
    logic       hext_q;
    logic       hit;

    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        logic [7:0] a;
        a = 8'h00;
        if (ASCII_EN) begin
            case (c)
                8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
                8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
                8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
                8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
                8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
                8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
                8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
                8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
                8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
                8'h3E: a = 8'h38; 8'h46: a = 8'h39;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    // Keyboard status replies (BAT ok, ack, echo, resend) carry no key information.
    function automatic logic is_status(input logic [7:0] c);
        return (c == 8'hAA) || (c == 8'hFA) || (c == 8'hEE) || (c == 8'hFE);
    endfunction

    assign hit = held_q && (hcode_q == fifo.data) && (hext_q == pe_q);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= IDLE;
            nextdata_n_q  <= 1'b1;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_break_q   <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_ascii_q   <= 8'h00;
            held_q        <= 1'b0;
            press_count_q <= 8'h00;
            sync_err_q    <= 1'b0;
            pe_q          <= 1'b0;
            pb_q          <= 1'b0;
            hcode_q       <= 8'h00;
            hext_q        <= 1'b0;
        end else begin
            key_valid_q  <= 1'b0;
            nextdata_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (fifo.ready) begin
                        state_q      <= POP;
                        nextdata_n_q <= 1'b0;
                        if (fifo.data == 8'hE0 || fifo.data == 8'hF0) begin
                            // A prefix after F0 can never be legal: resynchronise on it.
                            if (pb_q) begin
                                pe_q       <= 1'b0;
                                pb_q       <= 1'b0;
                                sync_err_q <= 1'b1;
                            end else if (fifo.data == 8'hE0) begin
                                pe_q <= 1'b1;
                            end else begin
                                pb_q <= 1'b1;
                            end
                        end else if (!is_status(fifo.data)) begin
                            key_valid_q <= 1'b1;
                            key_code_q  <= fifo.data;
                            key_ext_q   <= pe_q;
                            key_break_q <= pb_q;
                            pe_q        <= 1'b0;
                            pb_q        <= 1'b0;
                            if (pb_q) begin
                                key_repeat_q <= 1'b0;
                                key_ascii_q  <= 8'h00;
                                if (hit) held_q <= 1'b0;
                            end else begin
                                key_repeat_q <= hit;
                                key_ascii_q  <= pe_q ? 8'h00 : ascii_of(fifo.data);
                                if (!hit) begin
                                    press_count_q <= press_count_q + 8'd1;
                                    held_q        <= 1'b1;
                                    hcode_q       <= fifo.data;
                                    hext_q        <= pe_q;
                                end
                            end
                        end
                    end
                end
                POP:     state_q <= SETTLE;
                SETTLE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // Placed last so an event in the same cycle still used the old prefixes.
            if (fifo.overflow) begin
                sync_err_q <= 1'b1;
                pe_q       <= 1'b0;
                pb_q       <= 1'b0;
            end
        end
    end

    assign fifo.nextdata_n = nextdata_n_q;
    assign key_valid       = key_valid_q;
    assign key_code        = key_code_q;
    assign key_ext         = key_ext_q;
    assign key_break       = key_break_q;
    assign key_repeat      = key_repeat_q;
    assign key_ascii       = key_ascii_q;
    assign held            = held_q;
    assign press_count     = press_count_q;
    assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - bench for ps2_key_decoder with a FIFO source and a byte-level event model
module tb_ps2_key_decoder;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    ps2_fifo_if fifo_if ();

    logic       key_valid, key_ext, key_break, key_repeat, held, sync_err;
    logic [7:0] key_code, key_ascii, press_count;

    ps2_key_decoder #(.ASCII_EN(1'b1)) dut (
        .clk(clk), .clrn(clrn), .fifo(fifo_if),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_break(key_break), .key_repeat(key_repeat), .key_ascii(key_ascii),
        .held(held), .press_count(press_count), .sync_err(sync_err)
    );

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO source: bench pushes at posedge+2, DUT strobe pops at negedge.
    logic [7:0] q[$];
    task automatic fifo_update();
        fifo_if.ready = (q.size() != 0);
        fifo_if.data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    initial begin
        fifo_if.overflow = 1'b0;
        fifo_update();
    end

    always @(negedge clk) begin
        if (clrn && fifo_if.nextdata_n === 1'b0 && q.size() != 0) begin
            void'(q.pop_front());
            fifo_update();
        end
    end

    // What the DUT saw on the last active edge.
    logic       clrn_s, ready_s, ov_s;
    logic [7:0] head_s;
    always @(posedge clk) begin
        clrn_s  <= clrn;
        ready_s <= fifo_if.ready;
        ov_s    <= fifo_if.overflow;
        head_s  <= fifo_if.data;
    end

    // Model state
    logic       m_pe, m_pb, m_held, m_serr;
    logic [8:0] m_hkey;
    logic [7:0] m_pc;
    int         m_since;
    logic [7:0] e_code, e_ascii;
    logic       e_ext, e_brk, e_rep;

    function automatic logic [7:0] model_ascii(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (LETTERS[i] == c) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (DIGITS[i] == c) return 8'h30 + 8'(i);
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_pe = 0; m_pb = 0; m_held = 0; m_serr = 0; m_hkey = '0; m_pc = 0; m_since = 3;
        e_code = 0; e_ascii = 0; e_ext = 0; e_brk = 0; e_rep = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic ev);
        ev = 1'b0;
        if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
            // status byte: nothing changes
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (m_pb) begin
                m_pe = 0; m_pb = 0; m_serr = 1;
            end else if (b == 8'hE0) m_pe = 1;
            else m_pb = 1;
        end else begin
            ev = 1'b1;
            e_code = b; e_ext = m_pe; e_brk = m_pb;
            if (m_pb) begin
                e_rep = 0; e_ascii = 0;
                if (m_held && m_hkey == {m_pe, b}) m_held = 0;
            end else begin
                e_rep   = m_held && m_hkey == {m_pe, b};
                e_ascii = m_pe ? 8'h00 : model_ascii(b);
                if (!e_rep) begin
                    m_pc = m_pc + 8'd1; m_held = 1; m_hkey = {m_pe, b};
                end
            end
            m_pe = 0; m_pb = 0;
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic ev, pop_exp;
        ev = 0; pop_exp = 0;
        if (clrn !== 1'b1 || clrn_s !== 1'b1) begin
            model_reset();
        end else begin
            pop_exp = ready_s && (m_since >= 3);
            if (pop_exp) begin
                m_since = 1;
                model_byte(head_s, ev);
            end else if (m_since < 3) m_since++;
            if (ov_s) begin
                m_serr = 1; m_pe = 0; m_pb = 0;
            end
        end
        check("nextdata_n", 32'(fifo_if.nextdata_n), 32'(!pop_exp));
        check("key_valid", 32'(key_valid), 32'(ev));
        check("key_code", 32'(key_code), 32'(e_code));
        check("key_ext", 32'(key_ext), 32'(e_ext));
        check("key_break", 32'(key_break), 32'(e_brk));
        check("key_repeat", 32'(key_repeat), 32'(e_rep));
        check("key_ascii", 32'(key_ascii), 32'(e_ascii));
        check("held", 32'(held), 32'(m_held));
        check("press_count", 32'(press_count), 32'(m_pc));
        check("sync_err", 32'(sync_err), 32'(m_serr));
    end

    // Segment counters and pop spacing
    int n_pulses, n_pops, cyc, last_pop, gmin, gmax;
    bit seg_clr, gap_en;
    initial begin n_pulses = 0; n_pops = 0; cyc = 0; last_pop = -1; gmin = 1000; gmax = 0; end
    always @(negedge clk) begin
        cyc++;
        if (seg_clr) begin
            n_pulses = 0; n_pops = 0;
        end
        if (key_valid === 1'b1) n_pulses++;
        if (fifo_if.nextdata_n === 1'b0) n_pops++;
        if (!gap_en) last_pop = -1;
        else if (fifo_if.nextdata_n === 1'b0) begin
            if (last_pop >= 0) begin
                if (cyc - last_pop < gmin) gmin = cyc - last_pop;
                if (cyc - last_pop > gmax) gmax = cyc - last_pop;
            end
            last_pop = cyc;
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk); #2;
        q.push_back(b);
        fifo_update();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        clrn = 1'b0;
        q.delete();
        fifo_update();
        fifo_if.overflow = 1'b0;
        seg_clr = 1'b1;
        @(posedge clk); #2;
        seg_clr = 1'b0;
        clrn = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
        check({"drain_", name}, q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_ov();
        @(posedge clk); #2 fifo_if.overflow = 1'b1;
        @(posedge clk); #2 fifo_if.overflow = 1'b0;
    endtask

    initial begin
        seg_clr = 1'b1;
        gap_en  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_nextdata_n", 32'(fifo_if.nextdata_n), 32'd1);
        check("rst_press_count", 32'(press_count), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        seg_clr = 1'b0;
        clrn = 1'b1;

        push(8'h1C);
        drain("single");
        check("single_code", 32'(key_code), 32'h1C);
        check("single_ascii", 32'(key_ascii), 32'h61);
        check("single_count", 32'(press_count), 32'd1);
        check("single_held", 32'(held), 32'd1);
        check("single_pops", n_pops, 1);
        check("single_pulses", n_pulses, 1);

        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        drain("repeat");
        check("repeat_pulses", n_pulses, 4);
        check("repeat_count", 32'(press_count), 32'd1);
        check("repeat_break", 32'(key_break), 32'd1);
        check("repeat_ascii", 32'(key_ascii), 32'd0);
        check("repeat_held", 32'(held), 32'd0);

        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain("ext");
        check("ext_code", 32'(key_code), 32'h75);
        check("ext_ext", 32'(key_ext), 32'd1);
        check("ext_break", 32'(key_break), 32'd1);
        check("ext_count", 32'(press_count), 32'd1);

        do_reset();
        push(8'hF0); push(8'hE0); push(8'h16);
        drain("illegal");
        check("illegal_serr", 32'(sync_err), 32'd1);
        check("illegal_ext", 32'(key_ext), 32'd0);
        check("illegal_break", 32'(key_break), 32'd0);
        check("illegal_ascii", 32'(key_ascii), 32'h31);

        do_reset();
        push(8'hE0); push(8'hAA); push(8'h75);
        drain("status");
        check("status_ext", 32'(key_ext), 32'd1);
        check("status_pulses", n_pulses, 1);

        do_reset();
        push(8'hE0);
        drain("ov_pre");
        pulse_ov();
        push(8'h75);
        drain("ov");
        check("ov_serr", 32'(sync_err), 32'd1);
        check("ov_ext", 32'(key_ext), 32'd0);
        check("ov_ascii", 32'(key_ascii), 32'd0);

        do_reset();
        push(8'hE0);
        drain("midrst_pre");
        do_reset();
        push(8'h16);
        drain("midrst");
        check("midrst_ext", 32'(key_ext), 32'd0);
        check("midrst_count", 32'(press_count), 32'd1);
        check("midrst_serr", 32'(sync_err), 32'd0);

        do_reset();
        gap_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = 8'h10 + 8'(i >> 1);
            if (i % 2 == 1) push(8'hE0);
            push(c);
            if (i % 2 == 1) push(8'hE0);
            push(8'hF0);
            push(c);
        end
        drain("wrap");
        gap_en = 1'b0;
        check("wrap_count", 32'(press_count), 32'd0);
        check("wrap_held", 32'(held), 32'd0);
        check("wrap_pulses", n_pulses, 512);
        check("wrap_gap_min", gmin, 3);
        check("wrap_gap_max", gmax, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream from the `ps2_keyboard` receiver FIFO and turns raw set-2 scan codes into key events. It handles the `E0` (extended) and `F0` (break) prefixes and suppresses typematic repeats for press counting. It also tracks the held key and maps letters and digits to ASCII. It sits directly downstream of `ps2_keyboard` and drives the `nextdata_n` pop strobe.

## Interface
- `ASCII_EN`, default 1: when 0, `key_ascii` is tied to 0 and the lookup is omitted.
- `clk` input 1: system clock; same clock as `ps2_keyboard`.
- `clrn` input 1: reset, asynchronous, active-low.
- `data` input 8: FIFO head byte from `ps2_keyboard`.
- `ready` input 1: FIFO non-empty.
- `overflow` input 1: FIFO overflow flag from `ps2_keyboard`.
- `nextdata_n` output 1: active-low pop strobe to `ps2_keyboard`.
- `key_valid` output 1: one-cycle pulse, event fields valid.
- `key_code` output 8: final (non-prefix) scan code of the event.
- `key_ext` output 1: event was `E0`-prefixed.
- `key_break` output 1: event is a release.
- `key_repeat` output 1: make event for the already-held key.
- `key_ascii` output 8: ASCII of a non-extended make; 0 otherwise.
- `held` output 1: a key is currently held.
- `press_count` output 8: count of new (non-repeat) make events.
- `sync_err` output 1: sticky; set on `overflow` or an illegal prefix sequence.

## Operation
- FSM states: IDLE, POP, SETTLE.
  - IDLE + `ready`=1 → POP. The decoder samples `data` and drives `nextdata_n`=0 for exactly that one cycle.
  - POP → SETTLE. `nextdata_n`=1. This cycle lets the FIFO read pointer advance.
  - SETTLE → IDLE.
  - Result: at most one byte is consumed every 3 cycles. `nextdata_n` is never low in two consecutive cycles.
- Prefix flags `pe` (E0 seen) and `pb` (F0 seen) are updated on each sampled byte:
  - `E0`: set `pe`. If `pb` is already set, clear both flags and set `sync_err`, because `F0 E0` is illegal.
  - `F0`: set `pb`. If `pb` is already set, treat it as illegal in the same way.
  - Any other byte `c`: emit an event with `key_code`=c, `key_ext`=`pe`, `key_break`=`pb`, then clear both flags.
  - Bytes `AA`, `FA`, `EE`, `FE` are ignored silently and the flags are unchanged.
- Held tracking uses internal registers `hcode[7:0]` and `hext`:
  - Make with `{pe,c}` equal to the held key: `key_repeat`=1. `press_count` is unchanged.
  - Make otherwise: `key_repeat`=0, `press_count` +1 (wraps 255→0), and the held key becomes `{pe,c}` with `held`=1.
  - Break matching the held key: `held`=0.
  - Break of any other key: event is emitted and `held` is unchanged.
- ASCII output is defined only for non-extended makes. Set-2 codes map as follows:
  - Letters (lowercase 'a'..'z'): 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Digits '0'..'9': 45 16 1E 26 25 2E 36 3D 3E 46.
  - Any other code gives 0. Breaks and extended events give 0.
- `overflow`=1 in any cycle sets `sync_err` and clears `pe` and `pb`. Decoding continues.
- `sync_err` clears only on reset.

## Timing
- Reset values: `nextdata_n`=1, `key_valid`=0, `key_code`=0, `key_ext`=0, `key_break`=0, `key_repeat`=0, `key_ascii`=0, `held`=0, `press_count`=0, `sync_err`=0, FSM=IDLE, internal flags cleared.
- Latency:
  - `data` is sampled on the edge that enters POP.
  - `key_valid` and all event fields are registered outputs and appear one cycle after that sample edge, in the POP cycle.
  - Fields hold their values until the next event. `key_valid` is high for exactly one cycle.
- `held` and `press_count` update in the same cycle as `key_valid`.
- When `ready` drops during SETTLE, the FSM returns to IDLE and waits. No pop is issued while `ready`=0.
- Reset asserted mid-sequence (for example after `E0` has been consumed) returns the block to reset values immediately. A partial prefix is discarded, and any pop in progress is abandoned with `nextdata_n`=1.
- When `overflow` and an event occur in the same cycle, the event completes with the old flags, then the flags are cleared.

## Test plan
- Feed `1C`: one `key_valid` pulse with code 1C, ext=0, break=0, repeat=0, ascii 0x61. `press_count`=1, `held`=1. `nextdata_n` is low exactly 1 cycle.
- Feed `1C 1C 1C` then `F0 1C`: three make events (2nd and 3rd have repeat=1) and `press_count`=1. The break event has break=1, ascii 0, and `held` goes to 0. Exactly 4 `key_valid` pulses.
- Feed `E0 75` then `E0 F0 75`: events are {75, ext=1, break=0, ascii 0} and {75, ext=1, break=1}. `press_count`=1.
- Feed `F0 E0 16`: `sync_err`=1 and the flags are cleared. The `16` byte emits a make with ascii 0x31 and ext=0.
- Assert reset after `E0` is consumed, release it, then feed `16`: ext=0 and all counters restart from 0.
- Feed 256 distinct alternating make/break pairs: `press_count` wraps to 0. With `ready` held high continuously, pops are spaced exactly 3 cycles apart.
